// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle between the timer-control FSM and countdown_timer
interface countdown_timer_if #(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
);
    logic               start;
    logic               abort;
    logic               pause;
    logic               auto_reload;
    logic [CNT_W-1:0]   load_val;
    logic [PRESC_W-1:0] presc_val;
    logic               tim_zero;
    logic               running;
    logic               paused;
    logic [CNT_W-1:0]   count;

    modport master (
        output start, abort, pause, auto_reload, load_val, presc_val,
        input  tim_zero, running, paused, count
    );

    modport slave (
        input  start, abort, pause, auto_reload, load_val, presc_val,
        output tim_zero, running, paused, count
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - prescaled programmable down-counter with pause, abort, restart and auto-reload
module countdown_timer #(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   load_q, load_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               ar_q, ar_d;
    logic               tim_zero_q, tim_zero_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            load_q      <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            ar_q        <= 1'b0;
            tim_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            load_q      <= load_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            ar_q        <= ar_d;
            tim_zero_q  <= tim_zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        load_d      = load_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        ar_d        = ar_q;
        tim_zero_d  = 1'b0;

        if (tif.abort) begin
            state_d     = IDLE;
            count_d     = '0;
            presc_cnt_d = '0;
        end else if (tif.start) begin
            load_d      = tif.load_val;
            presc_d     = tif.presc_val;
            presc_cnt_d = tif.presc_val;
            ar_d        = tif.auto_reload;
            count_d     = tif.load_val;
            if (tif.load_val != '0) begin
                state_d = RUN;
            end else begin
                // A zero load expires at once and never re-arms, even in periodic mode.
                state_d    = IDLE;
                tim_zero_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (presc_cnt_q == '0 && count_q <= CNT_W'(1)) begin
                        // Expiry outranks a simultaneous pause request.
                        presc_cnt_d = presc_q;
                        tim_zero_d  = 1'b1;
                        if (ar_q) begin
                            count_d = load_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end else if (tif.pause) begin
                        state_d = HOLD;
                    end else if (presc_cnt_q != '0) begin
                        presc_cnt_d = presc_cnt_q - PRESC_W'(1);
                    end else begin
                        presc_cnt_d = presc_q;
                        count_d     = count_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!tif.pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tif.tim_zero = tim_zero_q;
    assign tif.running  = (state_q == RUN);
    assign tif.paused   = (state_q == HOLD);
    assign tif.count    = count_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   tz_seen;

    countdown_timer_if #(.CNT_W(16), .PRESC_W(8)) tif ();

    countdown_timer #(.CNT_W(16), .PRESC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] l, input logic [7:0] p, input logic ar);
        tif.start       = 1'b1;
        tif.load_val    = l;
        tif.presc_val   = p;
        tif.auto_reload = ar;
        step();
        tif.start       = 1'b0;
        tif.auto_reload = 1'b0;
    endtask

    task automatic do_abort();
        tif.abort = 1'b1;
        step();
        tif.abort = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        tif.start       = 1'b0;
        tif.abort       = 1'b0;
        tif.pause       = 1'b0;
        tif.auto_reload = 1'b0;
        tif.load_val    = '0;
        tif.presc_val   = '0;
        #12;
        chk("rst_count", 32'(tif.count), 0);
        chk("rst_running", 32'(tif.running), 0);
        chk("rst_paused", 32'(tif.paused), 0);
        chk("rst_tz", 32'(tif.tim_zero), 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // one-shot L=3 P=0
        do_start(16'd3, 8'd0, 1'b0);
        chk("os_e0_count", 32'(tif.count), 3);
        chk("os_e0_running", 32'(tif.running), 1);
        chk("os_e0_tz", 32'(tif.tim_zero), 0);
        step();
        chk("os_e1_count", 32'(tif.count), 2);
        step();
        chk("os_e2_count", 32'(tif.count), 1);
        chk("os_e2_tz", 32'(tif.tim_zero), 0);
        step();
        chk("os_e3_count", 32'(tif.count), 0);
        chk("os_e3_tz", 32'(tif.tim_zero), 1);
        chk("os_e3_running", 32'(tif.running), 0);
        step();
        chk("os_e4_tz", 32'(tif.tim_zero), 0);

        // prescaled L=2 P=2, no pause: expiry after E6
        do_start(16'd2, 8'd2, 1'b0);
        tz_seen = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (tif.tim_zero) tz_seen++;
        end
        chk("ps_early_tz", 32'(tz_seen), 0);
        chk("ps_e5_count", 32'(tif.count), 1);
        step();
        chk("ps_e6_tz", 32'(tif.tim_zero), 1);
        chk("ps_e6_count", 32'(tif.count), 0);

        // prescaled with pause sampled at E2..E4, released at E5: expiry after E10
        do_start(16'd2, 8'd2, 1'b0);
        step();
        tif.pause = 1'b1;
        step();
        chk("pz_e2_paused", 32'(tif.paused), 1);
        chk("pz_e2_count", 32'(tif.count), 2);
        step();
        step();
        tif.pause = 1'b0;
        step();
        chk("pz_e5_running", 32'(tif.running), 1);
        tz_seen = 0;
        for (int i = 6; i <= 9; i++) begin
            step();
            if (tif.tim_zero) tz_seen++;
        end
        chk("pz_early_tz", 32'(tz_seen), 0);
        step();
        chk("pz_e10_tz", 32'(tif.tim_zero), 1);
        chk("pz_e10_running", 32'(tif.running), 0);

        // auto-reload L=2 P=0
        do_start(16'd2, 8'd0, 1'b1);
        chk("ar_e0_count", 32'(tif.count), 2);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("ar_e%0d_count", k), 32'(tif.count), (k % 2 == 1) ? 1 : 2);
            chk($sformatf("ar_e%0d_tz", k), 32'(tif.tim_zero), (k % 2 == 0) ? 1 : 0);
        end
        chk("ar_running", 32'(tif.running), 1);
        do_abort();
        chk("ab_running", 32'(tif.running), 0);
        chk("ab_count", 32'(tif.count), 0);
        chk("ab_tz", 32'(tif.tim_zero), 0);

        // zero load, one-shot and periodic
        do_start(16'd0, 8'd3, 1'b0);
        chk("z_tz", 32'(tif.tim_zero), 1);
        chk("z_running", 32'(tif.running), 0);
        chk("z_count", 32'(tif.count), 0);
        step();
        chk("z_tz_after", 32'(tif.tim_zero), 0);
        do_start(16'd0, 8'd0, 1'b1);
        chk("zar_tz", 32'(tif.tim_zero), 1);
        chk("zar_running", 32'(tif.running), 0);
        tz_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (tif.tim_zero) tz_seen++;
        end
        chk("zar_no_repeat", 32'(tz_seen), 0);

        // abort together with start
        tif.abort = 1'b1;
        do_start(16'd7, 8'd0, 1'b0);
        tif.abort = 1'b0;
        chk("abst_running", 32'(tif.running), 0);
        chk("abst_count", 32'(tif.count), 0);
        chk("abst_tz", 32'(tif.tim_zero), 0);

        // restart on the terminal tick
        do_start(16'd1, 8'd0, 1'b0);
        do_start(16'd4, 8'd0, 1'b0);
        chk("rs_tz", 32'(tif.tim_zero), 0);
        chk("rs_count", 32'(tif.count), 4);
        chk("rs_running", 32'(tif.running), 1);
        do_abort();

        // asynchronous reset mid-count
        do_start(16'd5, 8'd0, 1'b0);
        step();
        step();
        chk("rm_pre_count", 32'(tif.count), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_count", 32'(tif.count), 0);
        chk("rm_running", 32'(tif.running), 0);
        chk("rm_tz", 32'(tif.tim_zero), 0);
        step();
        @(negedge clk);
        reset = 1'b0;
        tz_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tif.tim_zero || tif.running) tz_seen++;
        end
        chk("rm_idle_after", 32'(tz_seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
